// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arb_pkg;

    typedef enum logic {
        CPU_OWN = 1'b0,
        EXT_OWN = 1'b1
    } arb_state_e;

    localparam int MAX_WAIT_DEF = 4;
    localparam int WAIT_CNT_W   = 4;

    // Clamps a requested wait limit into the range the counter can represent.
    function automatic logic [WAIT_CNT_W-1:0] wait_limit(input int max_wait);
        if (max_wait < 1) begin
            return WAIT_CNT_W'(1);
        end else if (max_wait > 15) begin
            return WAIT_CNT_W'(15);
        end else begin
            return WAIT_CNT_W'(max_wait);
        end
    endfunction

endpackage

// File: rtl/dmem_arb_wait_ctr.sv
// Counts cycles an external request has waited and flags when a forced grant is due.
module dmem_arb_wait_ctr
    import dmem_arb_pkg::*;
#(
    parameter int MAX_WAIT = MAX_WAIT_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ext_req_i,
    input  logic                  ext_ack_i,
    output logic [WAIT_CNT_W-1:0] wait_cnt_o,
    output logic                  force_o
);

    localparam logic [WAIT_CNT_W-1:0] LIMIT = wait_limit(MAX_WAIT);
    localparam logic [WAIT_CNT_W-1:0] ONE   = {{(WAIT_CNT_W-1){1'b0}}, 1'b1};

    logic [WAIT_CNT_W-1:0] cnt_q;
    logic [WAIT_CNT_W-1:0] cnt_d;

    // Holds at the limit; the forced grant that follows clears it.
    always_comb begin
        cnt_d = cnt_q;
        if (!ext_req_i || ext_ack_i) begin
            cnt_d = '0;
        end else if (cnt_q != LIMIT) begin
            cnt_d = cnt_q + ONE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign wait_cnt_o = cnt_q;
    assign force_o    = ext_req_i & ~ext_ack_i & (cnt_q == LIMIT);

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the data RAM between the CPU data port and an external loader/debug port.
// Define DMEM_ARB_STARVE_EN to compile in the forced grant for a starving external port.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int DATA_BUS_WIDTH = 17,
    parameter int MAX_WAIT       = MAX_WAIT_DEF
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      cpu_read,
    input  logic                      cpu_write,
    input  logic [DATA_BUS_WIDTH-1:0] cpu_adr,
    input  logic [DATA_WIDTH-1:0]     cpu_wd,
    output logic [DATA_WIDTH-1:0]     cpu_rd,
    output logic                      cpu_stall,
    input  logic                      ext_req,
    input  logic                      ext_we,
    input  logic [DATA_BUS_WIDTH-1:0] ext_adr,
    input  logic [DATA_WIDTH-1:0]     ext_wd,
    output logic [DATA_WIDTH-1:0]     ext_rd,
    output logic                      ext_ack,
    output logic                      mem_we,
    output logic [DATA_BUS_WIDTH-1:0] mem_adr,
    output logic [DATA_WIDTH-1:0]     mem_wd,
    input  logic [DATA_WIDTH-1:0]     mem_rd,
    output logic                      dbg_state_o,
    output logic [WAIT_CNT_W-1:0]     dbg_wait_cnt_o
);

    arb_state_e            state_q;
    logic                  cpu_acc;
    logic                  ext_grant;
    logic                  force_grant;
    logic [WAIT_CNT_W-1:0] wait_cnt;

    assign cpu_acc = cpu_read | cpu_write;

    // Reset gates the strobes combinationally so they drop without a clock edge.
    always_comb begin
        mem_adr   = cpu_adr;
        mem_wd    = cpu_wd;
        mem_we    = 1'b0;
        ext_grant = 1'b0;
        case (state_q)
            CPU_OWN: begin
                if (cpu_acc) begin
                    mem_we = cpu_write;
                end else if (ext_req) begin
                    mem_adr   = ext_adr;
                    mem_wd    = ext_wd;
                    mem_we    = ext_we;
                    ext_grant = 1'b1;
                end
            end
            EXT_OWN: begin
                mem_adr   = ext_adr;
                mem_wd    = ext_wd;
                mem_we    = ext_req & ext_we;
                ext_grant = ext_req;
            end
            default: begin
                mem_we = 1'b0;
            end
        endcase
        if (reset) begin
            mem_we    = 1'b0;
            ext_grant = 1'b0;
        end
    end

    assign ext_ack = ext_grant;
    assign cpu_rd  = mem_rd;
    assign ext_rd  = mem_rd;

`ifdef DMEM_ARB_STARVE_EN
    dmem_arb_wait_ctr #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_ctr (
        .clk        (clk),
        .reset      (reset),
        .ext_req_i  (ext_req),
        .ext_ack_i  (ext_grant),
        .wait_cnt_o (wait_cnt),
        .force_o    (force_grant)
    );

    assign cpu_stall = ~reset & (state_q == EXT_OWN) & cpu_acc;
`else
    // External port is served only in CPU-idle cycles.
    assign wait_cnt    = '0;
    assign force_grant = 1'b0;
    assign cpu_stall   = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= CPU_OWN;
        end else begin
            case (state_q)
                CPU_OWN: if (force_grant) state_q <= EXT_OWN;
                EXT_OWN: state_q <= CPU_OWN;
                default: state_q <= CPU_OWN;
            endcase
        end
    end

    assign dbg_state_o    = state_q;
    assign dbg_wait_cnt_o = wait_cnt;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter with a small RAM model and an expected-value queue.
`timescale 1ns/1ps
module tb_dmem_arbiter;

    localparam int DW = 32;
    localparam int AW = 17;
    localparam int MW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          cpu_read;
    logic          cpu_write;
    logic [AW-1:0] cpu_adr;
    logic [DW-1:0] cpu_wd;
    logic [DW-1:0] cpu_rd;
    logic          cpu_stall;
    logic          ext_req;
    logic          ext_we;
    logic [AW-1:0] ext_adr;
    logic [DW-1:0] ext_wd;
    logic [DW-1:0] ext_rd;
    logic          ext_ack;
    logic          mem_we;
    logic [AW-1:0] mem_adr;
    logic [DW-1:0] mem_wd;
    logic [DW-1:0] mem_rd;
    logic          dbg_state;
    logic [3:0]    dbg_wait_cnt;

    logic [DW-1:0] ram [0:255];
    logic [DW-1:0] exp_q [$];
    int            total = 0;
    int            bad   = 0;

    dmem_arbiter #(
        .DATA_WIDTH     (DW),
        .DATA_BUS_WIDTH (AW),
        .MAX_WAIT       (MW)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .cpu_read       (cpu_read),
        .cpu_write      (cpu_write),
        .cpu_adr        (cpu_adr),
        .cpu_wd         (cpu_wd),
        .cpu_rd         (cpu_rd),
        .cpu_stall      (cpu_stall),
        .ext_req        (ext_req),
        .ext_we         (ext_we),
        .ext_adr        (ext_adr),
        .ext_wd         (ext_wd),
        .ext_rd         (ext_rd),
        .ext_ack        (ext_ack),
        .mem_we         (mem_we),
        .mem_adr        (mem_adr),
        .mem_wd         (mem_wd),
        .mem_rd         (mem_rd),
        .dbg_state_o    (dbg_state),
        .dbg_wait_cnt_o (dbg_wait_cnt)
    );

    // Clock and RAM model
    always #5 clk = ~clk;

    assign mem_rd = ram[mem_adr[7:0]];

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 256; i++) ram[i] <= '0;
        end else if (mem_we) begin
            ram[mem_adr[7:0]] <= mem_wd;
        end
    end

    // Checking and scoreboard
    task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input logic [DW-1:0] v);
        exp_q.push_back(v);
    endtask

    task automatic pop_check(input string tag, input logic [DW-1:0] got);
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s: no expected value queued, got=%0h", tag, got);
        end else begin
            check_eq(tag, got, exp_q.pop_front());
        end
    endtask

    task automatic expect_ctl(input logic stall, input logic ack, input logic we);
        push_exp(DW'(stall));
        push_exp(DW'(ack));
        push_exp(DW'(we));
    endtask

    task automatic sample_ctl(input string tag);
        pop_check({tag, "_stall"}, DW'(cpu_stall));
        pop_check({tag, "_ack"},   DW'(ext_ack));
        pop_check({tag, "_we"},    DW'(mem_we));
    endtask

    // Driver: inputs change on the falling edge, outputs are sampled 1ns later.
    task automatic drive(input logic cr, input logic cw, input logic [AW-1:0] ca,
                         input logic [DW-1:0] cd, input logic er, input logic ew,
                         input logic [AW-1:0] ea, input logic [DW-1:0] ed);
        @(negedge clk);
        cpu_read  = cr;
        cpu_write = cw;
        cpu_adr   = ca;
        cpu_wd    = cd;
        ext_req   = er;
        ext_we    = ew;
        ext_adr   = ea;
        ext_wd    = ed;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "time limit");
    end

    initial begin
        logic [AW-1:0] a;
        logic [DW-1:0] d;

        reset     = 1'b1;
        cpu_read  = 1'b0;
        cpu_write = 1'b1;
        cpu_adr   = 17'h005;
        cpu_wd    = 32'h1234;
        ext_req   = 1'b1;
        ext_we    = 1'b1;
        ext_adr   = 17'h006;
        ext_wd    = 32'h5678;
        #3;
        expect_ctl(1'b0, 1'b0, 1'b0);
        sample_ctl("rst");
        push_exp(0);
        pop_check("rst_state", DW'(dbg_state));
        push_exp(0);
        pop_check("rst_wcnt", DW'(dbg_wait_cnt));
        @(negedge clk);
        cpu_write = 1'b0;
        ext_req   = 1'b0;
        @(negedge clk);
        reset = 1'b0;

        // Idle CPU: external write granted in the same cycle, then read back by the CPU
        drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 17'h0ff, 32'h14);
        expect_ctl(1'b0, 1'b1, 1'b1);
        sample_ctl("s1_ext_wr");
        push_exp(32'h0ff);
        pop_check("s1_adr", DW'(mem_adr));
        push_exp(32'h14);
        pop_check("s1_wd", mem_wd);
        drive(1'b1, 1'b0, 17'h0ff, '0, 1'b0, 1'b0, '0, '0);
        expect_ctl(1'b0, 1'b0, 1'b0);
        sample_ctl("s1_cpu_rd_ctl");
        push_exp(32'h14);
        pop_check("s1_cpu_rd", cpu_rd);
        drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 17'h0ff, '0);
        expect_ctl(1'b0, 1'b1, 1'b0);
        sample_ctl("ext_rd_ctl");
        push_exp(32'h14);
        pop_check("ext_rd", ext_rd);

        // No request: CPU values on the bus, no write
        a = AW'($urandom_range(0, 255));
        d = $urandom;
        drive(1'b0, 1'b0, a, d, 1'b0, 1'b1, 17'h0aa, 32'hffff);
        push_exp(0);
        pop_check("idle_we", DW'(mem_we));
        push_exp(DW'(a));
        pop_check("idle_adr", DW'(mem_adr));
        push_exp(d);
        pop_check("idle_wd", mem_wd);

        // CPU and external write collide: CPU wins, external write never lands
        drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 17'h00a, 32'h33);
        drive(1'b0, 1'b1, 17'h00a, 32'h0, 1'b1, 1'b1, 17'h00a, 32'h55);
        expect_ctl(1'b0, 1'b0, 1'b1);
        sample_ctl("s4_collide");
        push_exp(32'h0);
        pop_check("s4_wd", mem_wd);
        drive(1'b1, 1'b0, 17'h00a, '0, 1'b0, 1'b0, '0, '0);
        push_exp(32'h0);
        pop_check("s4_mem", cpu_rd);

        // Read and write together behave as a write
        drive(1'b1, 1'b1, 17'h020, 32'hdeadbeef, 1'b0, 1'b0, '0, '0);
        expect_ctl(1'b0, 1'b0, 1'b1);
        sample_ctl("rw_both");
        drive(1'b1, 1'b0, 17'h020, '0, 1'b0, 1'b0, '0, '0);
        push_exp(32'hdeadbeef);
        pop_check("rw_both_rd", cpu_rd);

        // Random CPU write/read-back through the queue
        for (int i = 0; i < 8; i++) begin
            d = $urandom;
            drive(1'b0, 1'b1, AW'(17'h030 + i), d, 1'b0, 1'b0, '0, '0);
            push_exp(d);
        end
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b0, AW'(17'h030 + i), '0, 1'b0, 1'b0, '0, '0);
            pop_check("rand_rd", cpu_rd);
        end
        idle();

`ifdef DMEM_ARB_STARVE_EN
        // Busy CPU: forced grant in the 5th cycle after ext_req rises
        for (int c = 0; c < 5; c++) begin
            drive(1'b0, 1'b1, AW'(17'h040 + c), DW'(c), 1'b1, 1'b1, 17'h0c0, 32'h5a);
            expect_ctl(1'b0, 1'b0, 1'b1);
            sample_ctl("s2_wait");
            push_exp(DW'(17'h040 + c));
            pop_check("s2_wait_adr", DW'(mem_adr));
        end
        drive(1'b0, 1'b1, 17'h045, 32'h5, 1'b1, 1'b1, 17'h0c0, 32'h5a);
        expect_ctl(1'b1, 1'b1, 1'b1);
        sample_ctl("s2_grant");
        push_exp(32'h0c0);
        pop_check("s2_grant_adr", DW'(mem_adr));
        push_exp(1);
        pop_check("s2_grant_state", DW'(dbg_state));
        drive(1'b0, 1'b1, 17'h045, 32'h5, 1'b0, 1'b0, '0, '0);
        expect_ctl(1'b0, 1'b0, 1'b1);
        sample_ctl("s2_after");
        drive(1'b1, 1'b0, 17'h0c0, '0, 1'b0, 1'b0, '0, '0);
        push_exp(32'h5a);
        pop_check("s2_mem", cpu_rd);

        // Request dropped at wait_cnt=4: no write, counter clears
        drive(1'b0, 1'b1, 17'h090, 32'h11, 1'b0, 1'b0, '0, '0);
        for (int c = 0; c < 4; c++) begin
            drive(1'b0, 1'b1, AW'(17'h050 + c), DW'(c), 1'b1, 1'b1, 17'h090, 32'hab);
        end
        drive(1'b0, 1'b1, 17'h054, 32'h4, 1'b0, 1'b1, 17'h090, 32'hab);
        push_exp(4);
        pop_check("s6_wcnt_at_drop", DW'(dbg_wait_cnt));
        expect_ctl(1'b0, 1'b0, 1'b1);
        sample_ctl("s6_drop");
        idle();
        push_exp(0);
        pop_check("s6_wcnt_after", DW'(dbg_wait_cnt));
        push_exp(0);
        pop_check("s6_state_after", DW'(dbg_state));
        drive(1'b1, 1'b0, 17'h090, '0, 1'b0, 1'b0, '0, '0);
        push_exp(32'h11);
        pop_check("s6_mem", cpu_rd);

        // Request dropped after the forced grant was committed
        for (int c = 0; c < 5; c++) begin
            drive(1'b0, 1'b1, AW'(17'h060 + c), DW'(c), 1'b1, 1'b1, 17'h091, 32'hcd);
        end
        drive(1'b0, 1'b1, 17'h065, 32'h5, 1'b0, 1'b1, 17'h091, 32'hcd);
        expect_ctl(1'b1, 1'b0, 1'b0);
        sample_ctl("pend_drop");
        push_exp(1);
        pop_check("pend_state", DW'(dbg_state));
        drive(1'b1, 1'b0, 17'h091, '0, 1'b0, 1'b0, '0, '0);
        push_exp(0);
        pop_check("pend_state_next", DW'(dbg_state));
        push_exp(32'h0);
        pop_check("pend_mem", cpu_rd);

        // Reset in the middle of the EXT_OWN cycle
        for (int c = 0; c < 5; c++) begin
            drive(1'b0, 1'b1, AW'(17'h070 + c), DW'(c), 1'b1, 1'b1, 17'h092, 32'hee);
        end
        drive(1'b0, 1'b1, 17'h075, 32'h5, 1'b1, 1'b1, 17'h092, 32'hee);
        expect_ctl(1'b1, 1'b1, 1'b1);
        sample_ctl("s5_pre");
        #1;
        reset = 1'b1;
        #1;
        expect_ctl(1'b0, 1'b0, 1'b0);
        sample_ctl("s5_async");
        push_exp(0);
        pop_check("s5_state_rst", DW'(dbg_state));
        @(negedge clk);
        reset = 1'b0;
        drive(1'b0, 1'b1, 17'h076, 32'h6, 1'b0, 1'b0, '0, '0);
        expect_ctl(1'b0, 1'b0, 1'b1);
        sample_ctl("s5_after");
        push_exp(0);
        pop_check("s5_state_after", DW'(dbg_state));
        push_exp(0);
        pop_check("s5_wcnt_after", DW'(dbg_wait_cnt));
`else
        // Busy CPU without the forced grant: external port keeps waiting
        for (int c = 0; c < 10; c++) begin
            drive(1'b0, 1'b1, AW'(17'h040 + c), DW'(c), 1'b1, 1'b1, 17'h0c0, 32'h5a);
            expect_ctl(1'b0, 1'b0, 1'b1);
            sample_ctl("s3_busy");
            push_exp(0);
            pop_check("s3_state", DW'(dbg_state));
        end
        drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 17'h0c0, 32'h5a);
        expect_ctl(1'b0, 1'b1, 1'b1);
        sample_ctl("s3_idle_grant");
        drive(1'b1, 1'b0, 17'h0c0, '0, 1'b0, 1'b0, '0, '0);
        push_exp(32'h5a);
        pop_check("s3_mem", cpu_rd);
`endif

        idle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
- REQ-001: Parameter DATA_WIDTH, default 32: data word width.
- REQ-002: Parameter DATA_BUS_WIDTH, default 17: data address width.
- REQ-003: Parameter MAX_WAIT, default 4: number of cycles an external request waits before a forced grant; legal range 1..15.
- REQ-004: clk  in  1  single clock; all state SHALL update on its rising edge.
- REQ-005: reset  in  1  asynchronous, active-high reset.
- REQ-006: cpu_read  in  1  CPU data-port read request, valid for the current cycle.
- REQ-007: cpu_write  in  1  CPU data-port write request, valid for the current cycle.
- REQ-008: cpu_adr  in  DATA_BUS_WIDTH  CPU data address.
- REQ-009: cpu_wd  in  DATA_WIDTH  CPU write data.
- REQ-010: cpu_rd  out  DATA_WIDTH  CPU read data; mem_rd passed straight through.
- REQ-011: cpu_stall  out  1  CPU SHALL hold its MEM stage while this signal is high.
- REQ-012: ext_req  in  1  external (loader/debug) access request; held high until ext_ack.
- REQ-013: ext_we  in  1  external access is a write.
- REQ-014: ext_adr  in  DATA_BUS_WIDTH  external address.
- REQ-015: ext_wd  in  DATA_WIDTH  external write data.
- REQ-016: ext_rd  out  DATA_WIDTH  external read data; mem_rd passed straight through, valid in the ext_ack cycle.
- REQ-017: ext_ack  out  1  one-cycle pulse marking the cycle the external access is performed.
- REQ-018: mem_we  out  1  write enable to dataram.
- REQ-019: mem_adr  out  DATA_BUS_WIDTH  address to dataram.
- REQ-020: mem_wd  out  DATA_WIDTH  write data to dataram.
- REQ-021: mem_rd  in  DATA_WIDTH  combinational read data from dataram.

Function
- REQ-022: The FSM SHALL have two states, CPU_OWN and EXT_OWN.
- REQ-023: In CPU_OWN with cpu_read or cpu_write set, mem_* SHALL carry the CPU access, mem_we SHALL equal cpu_write, cpu_stall SHALL be 0, and ext_ack SHALL be 0.
- REQ-024: In CPU_OWN with no CPU access and ext_req set, mem_* SHALL carry the external access in the same cycle, with mem_we = ext_we and ext_ack = 1 (zero-latency grant).
- REQ-025: wait_cnt SHALL increment each cycle in which ext_req=1 and ext_ack=0, and SHALL clear on ext_ack or ext_req=0.
- REQ-026: When wait_cnt reaches MAX_WAIT with ext_req=1, the next state SHALL be EXT_OWN.
- REQ-027: EXT_OWN SHALL last exactly one cycle. In that cycle, mem_* carries the external access, ext_ack=1, and cpu_stall=1 if the CPU requests access, else 0. The next state SHALL be CPU_OWN.
- REQ-028: A write by the port not granted SHALL never reach mem_we.
- REQ-029: cpu_read and cpu_write both set SHALL be treated as a write.
- REQ-030: When ext_req drops before ack, the request SHALL be abandoned with no memory effect. A pending transition to EXT_OWN SHALL still occur, with ext_ack=0 and mem_we=0.
- REQ-031: With no request, mem_we SHALL be 0. mem_adr and mem_wd SHALL carry the CPU values.

Reset
- REQ-032: Asserting reset SHALL immediately force state=CPU_OWN, wait_cnt=0, cpu_stall=0, ext_ack=0, and mem_we=0, including during an EXT_OWN cycle.
- REQ-033: The first cycle after reset release SHALL use CPU_OWN rules.

Configuration
- REQ-034: With macro DMEM_ARB_STARVE_EN defined, REQ-025 to REQ-027 (the forced grant) SHALL be compiled in.
- REQ-035: Without DMEM_ARB_STARVE_EN, the arbiter SHALL never enter EXT_OWN, cpu_stall SHALL be tied to 0, and the external port SHALL be served only in CPU-idle cycles.

Structure
- REQ-036: Package dmem_arb_pkg SHALL hold the state enum (CPU_OWN, EXT_OWN), the MAX_WAIT default, and the wait_cnt width constant (4 bits).
- REQ-037: The wait counter and threshold compare SHALL be sub-module dmem_arb_wait_ctr. It SHALL be instantiated only under DMEM_ARB_STARVE_EN.

Verification
- REQ-038: Scenario 1: CPU idle, ext write adr 0x0ff, data 0x14 -> ext_ack same cycle, mem_we=1, and a subsequent CPU read of 0x0ff returns 0x14.
- REQ-039: Scenario 2: CPU writes every cycle, ext_req held, MAX_WAIT=4, STARVE_EN defined -> cpu_stall=1 and ext_ack=1 in the 5th cycle after ext_req rises, then cpu_stall=0.
- REQ-040: Scenario 3: same stimulus as Scenario 2 with STARVE_EN undefined -> ext_ack never asserts and cpu_stall stays 0.
- REQ-041: Scenario 4: CPU write 0x00a/0x0 and ext write 0x00a/0x55 in the same cycle in CPU_OWN -> memory holds 0x0 and ext_ack=0.
- REQ-042: Scenario 5: reset asserted during the EXT_OWN cycle -> cpu_stall, ext_ack, and mem_we drop to 0 without waiting for a clock edge, and the state after release is CPU_OWN.
- REQ-043: Scenario 6: ext_req dropped at wait_cnt=4 -> no memory write occurs, and wait_cnt reads 0 on the following cycle.
